// File: rtl/polar_encode_pipe.sv
// Pipelined polar encoder: x = (u & ~frozen) * F^(kron log2 N), one butterfly stage per register.
// Define POLAR_BIT_REVERSE_EN to present x in bit-reversed index order.
module polar_encode_pipe #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] u,
    input  logic [N-1:0] frozen,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] x,
    output logic         busy,
    output logic [15:0]  block_count
);

    localparam int LOG2N = $clog2(N);

    logic [N-1:0]     v_q    [LOG2N];
    logic [N-1:0]     stg_in [LOG2N];
    logic [N-1:0]     nxt    [LOG2N];
    logic [LOG2N-1:0] vld_q;
    logic             advance;
    logic [N-1:0]     x_nat;

    assign out_valid = vld_q[LOG2N-1];
    assign advance   = out_ready | ~out_valid;
    assign in_ready  = advance;
    assign busy      = |vld_q;
    assign x_nat     = v_q[LOG2N-1];

    // Stage s folds the upper half of each 2^(s+1) group into the lower half.
    always_comb begin
        stg_in[0] = u & ~frozen;
        for (int s = 1; s < LOG2N; s++) begin
            stg_in[s] = v_q[s-1];
        end
        for (int s = 0; s < LOG2N; s++) begin
            nxt[s] = stg_in[s];
            for (int i = 0; i < N; i++) begin
                if (((i >> s) & 1) == 0) begin
                    nxt[s][i] = stg_in[s][i] ^ stg_in[s][i | (1 << s)];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LOG2N; s++) begin
                v_q[s] <= '0;
            end
            vld_q       <= '0;
            block_count <= '0;
        end else begin
            if (advance) begin
                for (int s = 0; s < LOG2N; s++) begin
                    v_q[s] <= nxt[s];
                end
                vld_q[0] <= in_valid;
                for (int s = 1; s < LOG2N; s++) begin
                    vld_q[s] <= vld_q[s-1];
                end
            end
            if (out_valid && out_ready) begin
                block_count <= block_count + 16'd1;
            end
        end
    end

`ifdef POLAR_BIT_REVERSE_EN
    function automatic int bitrev(input int i);
        int r;
        r = 0;
        for (int b = 0; b < LOG2N; b++) begin
            if (((i >> b) & 1) != 0) begin
                r = r | (1 << (LOG2N - 1 - b));
            end
        end
        return r;
    endfunction

    always_comb begin
        x = '0;
        for (int i = 0; i < N; i++) begin
            x[bitrev(i)] = x_nat[i];
        end
    end
`else
    assign x = x_nat;
`endif

endmodule

// File: doc/polar_encode_pipe.md
POLAR_ENCODE_PIPE -- requirements
Module: polar_encode_pipe

Interface
REQ-001 SHALL have parameter N, default 8, meaning block length in bits; legal values are powers of two from 2 to 1024.
REQ-002 SHALL have derived localparam LOG2N = $clog2(N), meaning the number of butterfly stages.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic rises on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit, the reset, which is asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the u/frozen block is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts input this cycle.
REQ-007 SHALL have port u, input, N bits: u[i] is the source bit at index i.
REQ-008 SHALL have port frozen, input, N bits: frozen[i]=1 forces u[i] to 0; it is sampled with u.
REQ-009 SHALL have port out_valid, output, 1 bit: x holds a complete codeword.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts x.
REQ-011 SHALL have port x, output, N bits: the encoded codeword.
REQ-012 SHALL have port busy, output, 1 bit: OR of all stage valid flags.
REQ-013 SHALL have port block_count, output, 16 bits: the number of codewords delivered, wrapping modulo 2^16.

Function
REQ-014 SHALL compute x = (u AND NOT frozen) * F^(kron LOG2N) over GF(2), with F = [1 0; 1 1], in natural (non-bit-reversed) index order unless REQ-030 applies.
REQ-015 SHALL implement LOG2N registered stages. Stage s (0-based) updates pairs (i, i+2^s) for every i with bit s of i equal to 0: v[i] <= v[i] XOR v[i+2^s], and v[i+2^s] <= v[i+2^s].
REQ-016 SHALL apply frozen masking combinationally ahead of the stage-0 register.
REQ-017 SHALL give a latency of exactly LOG2N cycles from the accepting edge (in_valid && in_ready) to out_valid=1 when there are no stalls.
REQ-018 SHALL drive advance = out_ready OR NOT out_valid; every stage register and valid flag updates only when advance=1.
REQ-019 SHALL drive in_ready = advance, combinationally. A block offered while in_ready=0 is not consumed and must be held by the source.
REQ-020 SHALL hold x and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL sustain a throughput of one block per cycle when in_valid=1 and out_ready=1 continuously.
REQ-022 SHALL advance bubbles (valid=0) like data; a bubble's data register contents are don't-care, but its valid flag stays 0.
REQ-023 SHALL increment block_count on every cycle with out_valid && out_ready, wrapping 16'hFFFF to 16'h0000.
REQ-024 SHALL let an input accept and an output delivery in the same cycle both take effect.
REQ-025 SHALL make u and frozen don't-care when in_valid=0.

Reset
REQ-026 SHALL, while rst=1, immediately clear all stage valid flags, all stage data registers, and block_count to 0, without waiting for a clock edge.
REQ-027 SHALL hold out_valid=0, x=0, busy=0, block_count=0 and in_ready=1 during reset.
REQ-028 SHALL discard any block in flight when reset is asserted mid-operation; no partial codeword appears after reset is released.
REQ-029 SHALL accept a new block on the first posedge clk after rst deasserts.

Configuration
REQ-030 SHALL, with POLAR_BIT_REVERSE_EN defined, present x in bit-reversed order: x[bitrev_LOG2N(i)] = natural x[i]. The reordering is pure wiring after the last stage and latency is unchanged.
REQ-031 SHALL, without POLAR_BIT_REVERSE_EN, present x in natural order as in REQ-014.

Verification
REQ-032 SHALL verify, with N=4, frozen=4'b0000, u=4'b0101 and out_ready=1: out_valid rises 2 cycles after accept and x=4'b0100 (macro off) or x=4'b0010 (macro on).
REQ-033 SHALL verify, with N=4, frozen=4'b0000 and u=4'b1111: x=4'b1000. Then, with frozen=4'b0111 and u=4'b1111: x=4'b1111.
REQ-034 SHALL verify, with N=8, 16 back-to-back blocks and out_ready=1: 16 consecutive out_valid cycles, each x matching the software model, and block_count=16.
REQ-035 SHALL verify that holding out_ready=0 for 5 cycles while the pipe is full gives in_ready=0, x stable and out_valid=1; after release, every block is delivered exactly once and in order.
REQ-036 SHALL verify that asserting rst for 1 cycle, between clock edges, with 2 blocks in flight gives out_valid=0, busy=0 and block_count=0 immediately, and that no stale codeword is emitted afterwards.
REQ-037 SHALL verify that, after 65535 deliveries, one more delivery wraps block_count from 16'hFFFF to 16'h0000.
